// File: rtl/spi_master_mc.sv
// spi_master_mc: SPI master with selectable CPOL/CPHA, programmable divider,
// multiple chip selects with optional SS hold, and a latched device interrupt.
module spi_master_mc #(
  parameter  int DW    = 8,
  parameter  int NCS   = 2,
  parameter  int DIV_W = 8,
  localparam int CSW   = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic             clk_26,
  input  logic             RESET_N,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_cpol,
  input  logic             cfg_cpha,
  input  logic [CSW-1:0]   cfg_cs,
  input  logic             cfg_hold,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [DW-1:0]    tx_data,
  output logic             rx_valid,
  output logic [DW-1:0]    rx_data,
  output logic             busy,
  output logic [NCS-1:0]   SS,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO,
  input  logic             INT,
  input  logic             irq_clr,
  output logic             irq
);

  localparam int ECW = $clog2(2 * DW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_END, S_GAP
  } state_t;

  state_t           r_state;
  logic             r_run;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_cpol;
  logic             r_cpha;
  logic [CSW-1:0]   r_cs;
  logic             r_hold;
  logic             r_held;
  logic [CSW-1:0]   r_held_cs;
  logic             r_pend;
  logic [DW-1:0]    r_tx_sh;
  logic [DW-1:0]    r_rx_sh;
  logic [ECW-1:0]   r_edge;
  logic [NCS-1:0]   r_ss;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_rx_valid;
  logic [DW-1:0]    r_rx_data;
  logic [2:0]       r_int_s;
  logic             r_irq;

  logic             w_tick;
  logic [ECW-1:0]   w_edge_n;
  logic             w_last;
  logic             w_sample;
  logic             w_shift;
  logic [DW-1:0]    w_rx_nxt;
  logic [NCS-1:0]   w_ss_cfg;
  logic [NCS-1:0]   w_ss_lat;
  logic             w_cs_ok;
  logic             w_int_rise;

  // Out-of-range selects decode to all-ones, i.e. no target.
  always_comb begin
    w_ss_cfg = '1;
    w_ss_lat = '1;
    for (int i = 0; i < NCS; i++) begin
      if (cfg_cs == CSW'(i)) w_ss_cfg[i] = 1'b0;
      if (r_cs == CSW'(i))   w_ss_lat[i] = 1'b0;
    end
  end

  assign w_cs_ok    = ~&w_ss_lat;
  assign w_tick     = (r_div_cnt == r_div);
  assign w_edge_n   = r_edge + ECW'(1);
  assign w_last     = (w_edge_n == ECW'(2 * DW));
  assign w_sample   = w_edge_n[0] ^ r_cpha;
  assign w_shift    = ~w_sample &
                      (r_cpha ? (w_edge_n != ECW'(1)) : ~w_last);
  assign w_rx_nxt   = w_sample ? {r_rx_sh[DW-2:0], MISO} : r_rx_sh;
  assign w_int_rise = r_int_s[1] & ~r_int_s[2];

  always_ff @(posedge clk_26 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_run      <= 1'b0;
      r_div      <= '0;
      r_div_cnt  <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_cs       <= '0;
      r_hold     <= 1'b0;
      r_held     <= 1'b0;
      r_held_cs  <= '0;
      r_pend     <= 1'b0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_edge     <= '0;
      r_ss       <= '1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_run      <= 1'b1;
      r_rx_valid <= 1'b0;
      if (r_state != S_IDLE)
        r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      unique case (r_state)
        S_IDLE: begin
          if (!r_held) r_sclk <= cfg_cpol;
          if (tx_valid && r_run) begin
            r_div     <= cfg_div;
            r_cpol    <= cfg_cpol;
            r_cpha    <= cfg_cpha;
            r_cs      <= cfg_cs;
            r_hold    <= cfg_hold;
            r_tx_sh   <= tx_data;
            r_div_cnt <= '0;
            r_sclk    <= cfg_cpol;
            if (r_held && (r_held_cs != cfg_cs)) begin
              r_ss    <= '1;
              r_held  <= 1'b0;
              r_pend  <= 1'b1;
              r_state <= S_GAP;
            end else begin
              r_ss    <= w_ss_cfg;
              r_mosi  <= tx_data[DW-1];
              r_state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (w_tick) begin
            r_edge  <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_tick) begin
            r_sclk  <= w_last ? r_cpol : ~r_sclk;
            r_edge  <= w_edge_n;
            r_rx_sh <= w_rx_nxt;
            if (w_shift) begin
              r_tx_sh <= r_tx_sh << 1;
              r_mosi  <= r_tx_sh[DW-2];
            end
            if (w_last) begin
              r_rx_data  <= w_rx_nxt;
              r_rx_valid <= 1'b1;
              r_state    <= S_END;
            end
          end
        end
        S_END: begin
          if (w_tick) begin
            if (r_hold && w_cs_ok) begin
              r_held    <= 1'b1;
              r_held_cs <= r_cs;
              r_state   <= S_IDLE;
            end else begin
              r_ss    <= '1;
              r_held  <= 1'b0;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (w_tick) begin
            if (r_pend) begin
              r_pend  <= 1'b0;
              r_ss    <= w_ss_lat;
              r_mosi  <= r_tx_sh[DW-1];
              r_state <= S_SETUP;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A new synchronised edge beats a simultaneous clear.
  always_ff @(posedge clk_26 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_int_s <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_int_s <= {r_int_s[1:0], INT};
      if (w_int_rise)   r_irq <= 1'b1;
      else if (irq_clr) r_irq <= 1'b0;
    end
  end

  assign tx_ready = (r_state == S_IDLE) & r_run;
  assign busy     = (r_state != S_IDLE);
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign SS       = r_ss;
  assign SCLK     = r_sclk;
  assign MOSI     = r_mosi;
  assign irq      = r_irq;

endmodule

// File: tb/tb_spi_master_mc.sv
// tb_spi_master_mc: directed checks of spi_master_mc using an 8-bit
// loopback instance and a 16-bit instance talking to a device model.
`timescale 1ns/1ps
module tb_spi_master_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] div8;
  logic       cpol8, cpha8, hold8, txv8, int8, clr8, lb8;
  logic [1:0] cs8;
  logic [7:0] txd8, rxd8;
  logic       rdy8, rxv8, busy8, sclk8, mosi8, irq8;
  logic [2:0] ss8;
  wire        miso8 = lb8 ? mosi8 : ~mosi8;

  spi_master_mc #(.DW(8), .NCS(3), .DIV_W(4)) u8 (
    .clk_26(clk), .RESET_N(rst_n),
    .cfg_div(div8), .cfg_cpol(cpol8), .cfg_cpha(cpha8),
    .cfg_cs(cs8), .cfg_hold(hold8),
    .tx_valid(txv8), .tx_ready(rdy8), .tx_data(txd8),
    .rx_valid(rxv8), .rx_data(rxd8), .busy(busy8),
    .SS(ss8), .SCLK(sclk8), .MOSI(mosi8), .MISO(miso8),
    .INT(int8), .irq_clr(clr8), .irq(irq8)
  );

  logic [7:0]  div16;
  logic        cpol16, cpha16, txv16;
  logic        rdy16, rxv16, busy16, sclk16, mosi16, irq16;
  logic [15:0] txd16, rxd16;
  logic [1:0]  ss16;
  logic        sl_miso = 1'b0;

  spi_master_mc #(.DW(16), .NCS(2), .DIV_W(8)) u16 (
    .clk_26(clk), .RESET_N(rst_n),
    .cfg_div(div16), .cfg_cpol(cpol16), .cfg_cpha(cpha16),
    .cfg_cs(1'b0), .cfg_hold(1'b0),
    .tx_valid(txv16), .tx_ready(rdy16), .tx_data(txd16),
    .rx_valid(rxv16), .rx_data(rxd16), .busy(busy16),
    .SS(ss16), .SCLK(sclk16), .MOSI(mosi16), .MISO(sl_miso),
    .INT(1'b0), .irq_clr(1'b0), .irq(irq16)
  );

  int e8 = 0;
  always @(sclk8) e8++;

  // Device model: answers 0xBEEF MSB first, captures what the master sends.
  logic        m_cpha = 1'b0;
  logic [15:0] sl_sh = '0;
  logic [15:0] sl_cap = '0;
  int          sl_e = 0;
  logic        ss_q = 1'b1;
  logic        sclk_q = 1'b0;
  always @(ss16[0], sclk16) begin
    if (ss16[0] === 1'b0 && ss_q === 1'b1) begin
      sl_e    = 0;
      sl_sh   = 16'hBEEF;
      sl_miso = sl_sh[15];
      sl_cap  = '0;
    end else if (ss16[0] === 1'b0 && sclk16 !== sclk_q) begin
      sl_e++;
      if (sl_e[0] ^ m_cpha) begin
        sl_cap = {sl_cap[14:0], mosi16};
      end else if (!m_cpha || sl_e != 1) begin
        sl_sh   = sl_sh << 1;
        sl_miso = sl_sh[15];
      end
    end
    ss_q   = ss16[0];
    sclk_q = sclk16;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (busy8 && n < 600) begin @(negedge clk); n++; end
    chk("idle8_reached", busy8, 1'b0);
  endtask

  task automatic run8(input logic [3:0] div, input logic cpol,
                      input logic cpha, input logic [1:0] cs,
                      input logic [7:0] tx, input logic lb,
                      output logic got, output logic [7:0] rx,
                      output int edges, output int cyc,
                      output logic [2:0] low, output logic pulse1);
    int e0;
    int n;
    @(negedge clk);
    div8 = div; cpol8 = cpol; cpha8 = cpha; cs8 = cs;
    hold8 = 1'b0; lb8 = lb; txd8 = tx;
    repeat (3) @(negedge clk);
    txv8 = 1'b1;
    n = 0;
    while (!rdy8 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    txv8 = 1'b0;
    div8 = ~div; cpol8 = ~cpol; cpha8 = ~cpha;
    cs8 = cs ^ 2'b01; hold8 = 1'b1;
    e0 = e8;
    low = ~ss8;
    cyc = 0;
    while (!rxv8 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      low |= ~ss8;
    end
    got = rxv8;
    rx = rxd8;
    edges = e8 - e0;
    div8 = div; cpol8 = cpol; cpha8 = cpha; cs8 = cs; hold8 = 1'b0;
    @(negedge clk);
    pulse1 = ~rxv8;
    low |= ~ss8;
  endtask

  typedef struct {
    logic [3:0] div;
    logic       cpol;
    logic       cpha;
    logic [1:0] cs;
    logic [7:0] tx;
    logic       lb;
    logic [7:0] exp_rx;
    logic [2:0] exp_low;
  } v8_t;

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [15:0] tx;
    logic [15:0] exp_rx;
  } v16_t;

  v8_t  t8[5];
  v16_t t16[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       got, p1;
    logic [7:0] rx;
    logic [2:0] low;
    int         edges, cyc, n, k, nrx, ss_bad, idle, gap, ovl, e0, nrv;
    logic       pend;
    logic [7:0] words[4];

    t8[0] = '{4'd0,  1'b0, 1'b0, 2'd0, 8'hA5, 1'b1, 8'hA5, 3'b001};
    t8[1] = '{4'd3,  1'b1, 1'b1, 2'd2, 8'h3C, 1'b0, 8'hC3, 3'b100};
    t8[2] = '{4'd1,  1'b0, 1'b1, 2'd1, 8'h81, 1'b1, 8'h81, 3'b010};
    t8[3] = '{4'd2,  1'b1, 1'b0, 2'd3, 8'h5A, 1'b1, 8'h5A, 3'b000};
    t8[4] = '{4'd15, 1'b0, 1'b0, 2'd0, 8'hF0, 1'b0, 8'h0F, 3'b001};
    t16[0] = '{1'b0, 1'b0, 16'h1234, 16'hBEEF};
    t16[1] = '{1'b0, 1'b1, 16'h1234, 16'hBEEF};
    t16[2] = '{1'b1, 1'b0, 16'h1234, 16'hBEEF};
    t16[3] = '{1'b1, 1'b1, 16'h1234, 16'hBEEF};
    words = '{8'h11, 8'h22, 8'h33, 8'h44};

    div8 = '0; cpol8 = 0; cpha8 = 0; hold8 = 0; txv8 = 0;
    int8 = 0; clr8 = 0; lb8 = 1; cs8 = '0; txd8 = '0;
    div16 = 8'd1; cpol16 = 0; cpha16 = 0; txv16 = 0; txd16 = '0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ss8", ss8, 3'b111);
    chk("rst_sclk8", sclk8, 1'b0);
    chk("rst_mosi8", mosi8, 1'b0);
    chk("rst_rdy8", rdy8, 1'b0);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_rxv8", rxv8, 1'b0);
    chk("rst_rxd8", rxd8, 8'h00);
    chk("rst_irq8", irq8, 1'b0);
    chk("rst_ss16", ss16, 2'b11);
    rst_n = 1'b1;
    #1 chk("rdy_before_edge", rdy8, 1'b0);
    @(posedge clk);
    #1 chk("rdy_first_edge", rdy8, 1'b1);

    for (int i = 0; i < 5; i++) begin
      run8(t8[i].div, t8[i].cpol, t8[i].cpha, t8[i].cs, t8[i].tx,
           t8[i].lb, got, rx, edges, cyc, low, p1);
      chk($sformatf("v%0d_rxv", i), got, 1'b1);
      chk($sformatf("v%0d_rxd", i), rx, t8[i].exp_rx);
      chk($sformatf("v%0d_edges", i), edges, 16);
      chk($sformatf("v%0d_cycles", i), cyc, (int'(t8[i].div) + 1) * 17);
      chk($sformatf("v%0d_ss_low", i), low, t8[i].exp_low);
      chk($sformatf("v%0d_pulse1", i), p1, 1'b1);
      wait_idle8();
      chk($sformatf("v%0d_ss_idle", i), ss8, 3'b111);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_sclk_idle", i), sclk8, t8[i].cpol);
    end

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpol16 = t16[i].cpol; cpha16 = t16[i].cpha;
      m_cpha = t16[i].cpha; txd16 = t16[i].tx;
      repeat (3) @(negedge clk);
      chk($sformatf("m%0d_sclk_pre", i), sclk16, t16[i].cpol);
      txv16 = 1'b1;
      n = 0;
      while (!rdy16 && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      txv16 = 1'b0;
      n = 0;
      while (!rxv16 && n < 1000) begin @(negedge clk); n++; end
      chk($sformatf("m%0d_rxv", i), rxv16, 1'b1);
      chk($sformatf("m%0d_rxd", i), rxd16, t16[i].exp_rx);
      n = 0;
      while (busy16 && n < 100) begin @(negedge clk); n++; end
      chk($sformatf("m%0d_mosi_cap", i), sl_cap, t16[i].tx);
      chk($sformatf("m%0d_sclk_idle", i), sclk16, t16[i].cpol);
    end

    @(negedge clk);
    div8 = 4'd1; cpol8 = 0; cpha8 = 0; cs8 = 2'd1; hold8 = 1'b1;
    lb8 = 1'b1; txd8 = words[0];
    repeat (3) @(negedge clk);
    txv8 = 1'b1;
    pend = rdy8;
    k = 0; nrx = 0; ss_bad = 0; idle = 0;
    for (int c = 0; c < 400 && nrx < 3; c++) begin
      @(negedge clk);
      if (pend) begin
        k++;
        pend = 1'b0;
        if (k < 3) txd8 = words[k];
        else txv8 = 1'b0;
      end
      if (k > 0 && ss8 !== 3'b101) ss_bad++;
      if (rxv8) begin
        chk($sformatf("hold_rx%0d", nrx), rxd8, words[nrx]);
        nrx++;
      end
      if (!busy8 && k > 0 && k < 3) idle++;
      if (rdy8 && txv8) pend = 1'b1;
    end
    chk("hold_words", nrx, 3);
    chk("hold_ss_bad", ss_bad, 0);
    chk("hold_idle_cycles", idle, 2);
    repeat (3) @(negedge clk);
    chk("hold_ss_kept", ss8, 3'b101);
    chk("hold_busy", busy8, 1'b0);

    cs8 = 2'd0; hold8 = 1'b0; txd8 = words[3]; txv8 = 1'b1;
    @(negedge clk);
    txv8 = 1'b0;
    gap = 0; ovl = 0; n = 0;
    while (ss8[0] !== 1'b0 && n < 100) begin
      if (ss8 === 3'b111) gap++;
      if (!ss8[0] && !ss8[1]) ovl++;
      @(negedge clk);
      n++;
    end
    chk("cs_switch_ss0_fell", ss8, 3'b110);
    chk("cs_switch_gap_ok", gap >= 2, 1'b1);
    chk("cs_switch_overlap", ovl, 0);
    n = 0;
    while (!rxv8 && n < 200) begin @(negedge clk); n++; end
    chk("cs_switch_rx", rxd8, words[3]);
    wait_idle8();
    chk("cs_switch_ss_idle", ss8, 3'b111);

    @(negedge clk);
    int8 = 1'b1;
    repeat (3) @(negedge clk);
    chk("irq_set", irq8, 1'b1);
    int8 = 1'b0;
    clr8 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
    chk("irq_clr", irq8, 1'b0);
    repeat (4) @(negedge clk);
    int8 = 1'b1;
    repeat (2) @(negedge clk);
    clr8 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
    int8 = 1'b0;
    chk("irq_set_wins", irq8, 1'b1);

    div8 = 4'd3; cpol8 = 0; cpha8 = 0; cs8 = 2'd0; hold8 = 0;
    lb8 = 1'b1; txd8 = 8'h96;
    repeat (3) @(negedge clk);
    txv8 = 1'b1;
    @(negedge clk);
    txv8 = 1'b0;
    e0 = e8; n = 0;
    while (e8 - e0 < 5 && n < 200) begin @(posedge clk); #1; n++; end
    chk("abort_edge5", e8 - e0, 5);
    rst_n = 1'b0;
    #1;
    chk("abort_ss", ss8, 3'b111);
    chk("abort_sclk", sclk8, 1'b0);
    chk("abort_mosi", mosi8, 1'b0);
    chk("abort_rdy", rdy8, 1'b0);
    chk("abort_busy", busy8, 1'b0);
    chk("abort_rxv", rxv8, 1'b0);
    chk("abort_rxd", rxd8, 8'h00);
    chk("abort_irq", irq8, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort_rdy_low", rdy8, 1'b0);
    @(posedge clk);
    #1 chk("abort_rdy_rise", rdy8, 1'b1);
    nrv = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rxv8) nrv++;
    end
    chk("abort_no_rxv", nrv, 0);
    run8(4'd2, 1'b0, 1'b1, 2'd2, 8'h6B, 1'b1, got, rx, edges, cyc, low, p1);
    chk("post_rxv", got, 1'b1);
    chk("post_rxd", rx, 8'h6B);
    chk("post_ss_low", low, 3'b100);
    wait_idle8();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_mc.md
SPI_MASTER_MC -- requirements
Module: spi_master_mc

Interface
REQ-001 SHALL have parameter DW, default 8, shift-word width in bits (legal 4..32).
REQ-002 SHALL have parameter NCS, default 2, chip-select count (legal 1..8).
REQ-003 SHALL have parameter DIV_W, default 8, clock-divider width.
REQ-004 SHALL have ports:
- clk_26  in  1  sole clock
- RESET_N  in  1  asynchronous, active-low reset
- cfg_div  in  DIV_W  SCLK half-period = cfg_div+1 clk_26 cycles
- cfg_cpol  in  1  SCLK idle level
- cfg_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- cfg_cs  in  max(1,clog2(NCS))  target chip select
- cfg_hold  in  1  keep SS asserted after the word
- tx_valid  in  1  word offered
- tx_ready  out  1  word accepted when tx_valid&tx_ready
- tx_data  in  DW  word to send, MSB first
- rx_valid  out  1  one-cycle pulse, rx_data updated
- rx_data  out  DW  last received word
- busy  out  1  transfer in progress
- SS  out  NCS  active-low chip selects
- SCLK, MOSI  out  1  SPI clock and data out
- MISO  in  1  SPI data in
- INT  in  1  asynchronous device interrupt, active high
- irq_clr  in  1  clears irq
- irq  out  1  latched interrupt

Function
REQ-005 SHALL implement states IDLE, SETUP, SHIFT, END, GAP.
REQ-006 tx_ready SHALL be 1 only in IDLE; on accept, cfg_* and tx_data SHALL be latched; later cfg_* changes SHALL NOT affect the word in flight.
REQ-007 IDLE->SETUP on accept; if SS is held for a different cs, IDLE->GAP first (old SS deasserted), then SETUP.
REQ-008 SETUP: SS[cs]=0, MOSI=MSB, one half-period, then SHIFT.
REQ-009 SHIFT: SCLK SHALL toggle every half-period, exactly 2*DW edges; CPHA=0 samples MISO on odd edges and shifts MOSI on even edges; CPHA=1 shifts on odd edges and samples on even edges.
REQ-010 After the last edge SCLK SHALL equal latched CPOL; the state SHALL go to END with rx_data updated and rx_valid=1 for exactly one cycle.
REQ-011 END: one half-period; if hold=1 -> IDLE with SS kept asserted; else SS deasserted -> GAP.
REQ-012 GAP: SS all 1 for one half-period minimum, then IDLE (or SETUP per REQ-007).
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 In IDLE, SCLK SHALL follow cfg_cpol combinationally-registered (1-cycle lag) only while no SS is held; MOSI SHALL hold its last value.
REQ-015 cfg_div=0 SHALL give SCLK = clk_26/2; cfg_div=all-ones SHALL give a half-period of 2^DIV_W cycles without counter overflow.
REQ-016 tx_valid asserted continuously with hold=1 and the same cs SHALL produce back-to-back words with SS low throughout and exactly one IDLE cycle between words.
REQ-017 INT SHALL pass a 2-flop synchroniser; a synchronised rising edge SHALL set irq; irq_clr SHALL clear it; simultaneous set and clear -> irq=1.
REQ-018 cfg_cs >= NCS SHALL be treated as no target: the word shifts with all SS=1.

Reset
REQ-019 RESET_N=0 SHALL immediately force: state IDLE, SS all 1, SCLK 0, MOSI 0, tx_ready 0, busy 0, rx_valid 0, rx_data 0, irq 0, synchroniser 0, divider 0.
REQ-020 Reset mid-transfer SHALL abort without an rx_valid pulse; tx_ready SHALL rise the first clk_26 edge after RESET_N deasserts.

Verification
REQ-021 DW=8, div=0, CPOL=0, CPHA=0, tx 0xA5, MISO loopback -> 16 SCLK edges at clk/2, rx_data=0xA5, one rx_valid pulse, SS[0] low only SETUP..END.
REQ-022 All four CPOL/CPHA modes, DW=16, tx 0x1234, device model returns 0xBEEF -> rx_data=0xBEEF each mode, SCLK idle level matches CPOL.
REQ-023 hold=1, three words cs=1, tx_valid held high -> SS[1] continuously low, SS[0] high, three rx_valid pulses; fourth word cs=0 -> SS[1] high for >=1 half-period before SS[0] falls.
REQ-024 div=3, RESET_N pulsed low at SCLK edge 5 -> outputs at reset values within the same cycle, no rx_valid, next transfer completes normally.
REQ-025 INT pulse 3 cycles wide -> irq=1 within 3 cycles; irq_clr in the same cycle as a second edge -> irq stays 1.
REQ-026 div=all-ones, DIV_W=4 -> SCLK half-period exactly 16 cycles.
